// File: rtl/stoch_window_decoder.sv
// -----------------------------------------------------------------------------
// stoch_window_decoder
//
// Integrates a signed stochastic bitstream pair (bit_p adds one, bit_m takes
// one away) over a window of N = 2^WIN_LOG2 clock cycles. The resulting count
// in -N..+N is presented through a one-entry result register with a
// valid/ready handshake. The block supports one-shot windows and back-to-back
// (continuous) windows with no gap cycle. A sticky overrun flag records that a
// result was overwritten before it was consumed.
//
// Ports
//   CLK        system clock, rising edge
//   nRST       asynchronous active-low reset
//   start      begin a window (only while idle)
//   stop       abort the running window (only while running)
//   cont       continuous mode, sampled on the last sample of each window
//   bit_p      positive-channel stochastic bit
//   bit_m      negative-channel stochastic bit
//   busy       window in progress
//   out_valid  result register holds an unconsumed result
//   out_ready  consumer accepts the result when out_valid is also high
//   out_value  signed window count, WIN_LOG2+2 bits
//   overrun    sticky: an unconsumed result was overwritten
// -----------------------------------------------------------------------------
module stoch_window_decoder #(
    parameter int WIN_LOG2 = 8
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       cont,
    input  logic                       bit_p,
    input  logic                       bit_m,
    output logic                       busy,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [WIN_LOG2+1:0] out_value,
    output logic                       overrun
);

    localparam int AW = WIN_LOG2 + 2;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]             state_q, state_d;
    logic signed [AW-1:0]   acc_q,   acc_d;
    logic [WIN_LOG2-1:0]    idx_q,   idx_d;
    logic                   vld_q,   vld_d;
    logic signed [AW-1:0]   val_q,   val_d;
    logic                   ovr_q,   ovr_d;

    logic signed [AW-1:0]   inc;
    logic signed [AW-1:0]   sum;
    logic                   last;

    // Per-sample increment: +1, -1, or 0 (both or neither bit set).
    always_comb begin
        inc = '0;
        if (bit_p && !bit_m) begin
            inc = AW'(1);
        end else if (!bit_p && bit_m) begin
            inc = {AW{1'b1}};
        end
    end

    assign sum  = acc_q + inc;
    assign last = (idx_q == {WIN_LOG2{1'b1}});

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        // A consume empties the register unless a new result loads below.
        vld_d   = vld_q && !out_ready;
        val_d   = val_q;
        ovr_d   = ovr_q;

        if (state_q == S_IDLE) begin
            // stop has priority over start in the same cycle.
            if (start && !stop) begin
                state_d = S_RUN;
                acc_d   = inc;
                idx_d   = WIN_LOG2'(1);
                ovr_d   = 1'b0;
            end
        end else begin
            if (stop) begin
                // Abort: partial window discarded, result register untouched.
                state_d = S_IDLE;
                acc_d   = '0;
                idx_d   = '0;
            end else if (!last) begin
                acc_d = sum;
                idx_d = idx_q + 1'b1;
            end else begin
                val_d = sum;
                vld_d = 1'b1;
                // Losing a result only counts if it was not taken this edge.
                if (vld_q && !out_ready) begin
                    ovr_d = 1'b1;
                end
                // Clearing acc here lets the next edge act as sample 0 of a
                // continuous window: acc becomes 0 + inc with no gap cycle.
                acc_d = '0;
                idx_d = '0;
                if (!cont) begin
                    state_d = S_IDLE;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            val_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            val_q   <= val_d;
            ovr_q   <= ovr_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign out_valid = vld_q;
    assign out_value = val_q;
    assign overrun   = ovr_q;

endmodule

// File: doc/stoch_window_decoder.md
# stoch_window_decoder

Converts a signed stochastic bitstream pair (positive/negative channel) into a signed fixed-point count over a window of 2^WIN_LOG2 clock cycles. Sits directly downstream of the stochastic dot-product and arithmetic stages: it consumes their output bitstreams and produces binary results for readout or for re-encoding. Supports one-shot and back-to-back (continuous) windows, with a valid/ready result handshake and overrun detection.

## Interface

Parameters:
- WIN_LOG2, default 8: log2 of the window length. N = 2^WIN_LOG2 samples per window. Legal range is 1..16.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- nRST  input  1  asynchronous, active-low reset.
- start  input  1  request to begin a window. Honoured only in IDLE.
- stop  input  1  abort the current window. Honoured only in RUN.
- cont  input  1  continuous mode. Sampled at each window end.
- bit_p  input  1  positive-channel stochastic bit.
- bit_m  input  1  negative-channel stochastic bit. Tie to 0 for unsigned streams.
- busy  output  1  high while in RUN.
- out_valid  output  1  the result register holds an unconsumed result.
- out_ready  input  1  the consumer accepts the result when this and out_valid are both high.
- out_value  output  WIN_LOG2+2  signed result: count(bit_p) − count(bit_m) over the window. Range is −N..+N.
- overrun  output  1  sticky flag: an unconsumed result was overwritten.

## Operation

- FSM has two states: IDLE and RUN.
- Internal signed accumulator `acc` is WIN_LOG2+2 bits wide. Sample counter `idx` is WIN_LOG2 bits wide.
- Per-sample increment is bit_p − bit_m, one of {−1, 0, +1}. When both bits are 1 in the same cycle they cancel. The accumulator cannot overflow.

IDLE:
- If start=1 and stop=0 at an edge: go to RUN.
  - Load acc with this cycle's increment. This cycle is sample 0.
  - Set idx to 1.
  - Clear overrun.
- If start=1 and stop=1 in the same cycle: stop wins. The block stays in IDLE and nothing is loaded.

RUN, at each edge:
- Sample the increment.
- If stop=1: discard the sample and acc, and go to IDLE. No result is produced. out_valid, out_value and overrun are unchanged.
- Otherwise, if idx ≠ N−1: acc += increment, idx += 1 (idx wraps to 0 at N).
- If idx = N−1 (last sample): load out_value with acc + increment and set out_valid=1.
  - If out_valid was already 1 and is not being consumed this same cycle, set overrun=1. The old result is lost.
  - If cont=1: stay in RUN. The next edge is sample 0 of the next window, with acc restarted from that sample's increment and no gap cycle.
  - If cont=0: go to IDLE.

Result handshake:
- out_valid clears on any edge where out_valid and out_ready are both high, unless a new result loads on that same edge. In that case out_valid stays 1, out_value takes the new result, and overrun is not set.
- out_value is stable while out_valid=1 and not consumed.
- start, stop and cont have no effect on the result register except through window completion.

Reset (nRST low, asynchronous):
- State → IDLE; acc, idx → 0.
- Outputs: busy=0, out_valid=0, out_value=0, overrun=0.
- Applies immediately, including mid-window. The partial window is discarded.

## Timing

- Start is accepted at edge E0. Samples are taken at E0..E(N−1).
- After E(N−1): out_valid=1 and out_value holds the result. Latency is N edges from start acceptance.
- busy rises after E0. In one-shot mode busy falls after E(N−1). In continuous mode busy stays high.
- Continuous throughput is one result every N cycles.
- The consumer must take each result within N cycles to avoid overrun.
- stop at edge Ek: busy=0 after Ek.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan

All scenarios use WIN_LOG2=3 (N=8).

1. One-shot, positive extreme: start pulse, bit_p=1, bit_m=0 for 8 cycles, out_ready=0. Expect out_valid=1 and out_value=+8 after the 8th edge, busy=0, and the result held until out_ready=1 (then out_valid=0 one edge later).
2. Mixed and extremes: bit_p=1010_1010, bit_m=1000_1000 → +2. bit_p=bit_m=1 for all samples → 0. bit_m=1, bit_p=0 for all samples → −8 (full negative range fits the width).
3. Continuous with overrun: cont=1, out_ready=0, bit_p=1 for window 1 and bit_p=0 for window 2. Expect out_value=+8 after edge 8, then 0 after edge 16 with overrun=1 and busy staying high. A subsequent start from IDLE clears overrun.
4. Continuous with simultaneous consume: cont=1, out_ready=1 exactly on the edge window 2 completes. Expect the new value loaded, out_valid staying 1 and overrun=0.
5. Abort and collision: stop=1 at sample 5 → IDLE with out_valid unchanged and no result ever produced. start=stop=1 in IDLE → stays IDLE with busy=0.
6. Reset mid-window: drop nRST asynchronously at sample 4. busy, out_valid, out_value and overrun go to 0 immediately. After release, a new start gives a correct full-window result with no residue from the aborted window.
